// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, credit-limited memory requests, in-order response FIFO to decode.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirect raises a sticky fetchFault and stalls requests.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        imemReqValid,
    input  logic        imemReqReady,
    output logic [31:0] imemAddr,
    input  logic        imemRspValid,
    input  logic [31:0] imemRspData,
    output logic        instrValid,
    input  logic        instrReady,
    output logic [31:0] instr,
    output logic [31:0] instrPc,
    input  logic        redirectValid,
    input  logic [31:0] redirectPc,
    output logic        fetchFault
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(BUF_DEPTH);

    logic [31:0]   req_pc;
    logic [31:0]   rsp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   buf_instr [BUF_DEPTH];
    logic [31:0]   buf_pc    [BUF_DEPTH];
    logic          fault;
    logic [31:0]   target;
    logic          accept;
    logic          push;
    logic          pop;

    // Low address bits never reach the PC registers; the align check looks at the raw target.
    assign target = redirectPc & 32'hFFFF_FFFC;

    // Credit covers both in-flight requests and buffered words, so a push can never overflow.
    assign imemReqValid = rstn && !redirectValid && !fault
                          && (({1'b0, outstanding} + {1'b0, count}) < DEPTH_W);
    assign imemAddr     = req_pc;
    assign accept       = imemReqValid && imemReqReady;

    assign instrValid   = (count != '0) && !redirectValid;
    assign instr        = buf_instr[rd_ptr];
    assign instrPc      = buf_pc[rd_ptr];
    assign pop          = instrValid && instrReady;
    assign push         = imemRspValid && !redirectValid && (drop_cnt == '0);

    assign fetchFault   = fault;

`ifndef FETCH_ALIGN_CHECK_EN
    assign fault = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            req_pc      <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_instr[i] <= '0;
                buf_pc[i]    <= '0;
            end
`ifdef FETCH_ALIGN_CHECK_EN
            fault       <= 1'b0;
`endif
        end else begin
            outstanding <= outstanding + CW'(accept) - CW'(imemRspValid);
            if (redirectValid) begin
                // Everything still in flight after this cycle is stale.
                req_pc   <= target;
                rsp_pc   <= target;
                drop_cnt <= outstanding - CW'(imemRspValid);
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
                fault    <= (redirectPc[1:0] != 2'b00);
`endif
            end else begin
                if (accept) begin
                    req_pc <= req_pc + 32'd4;
                end
                if (imemRspValid && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
                if (push) begin
                    buf_instr[wr_ptr] <= imemRspData;
                    buf_pc[wr_ptr]    <= rsp_pc;
                    wr_ptr            <= wr_ptr + PW'(1);
                    rsp_pc            <= rsp_pc + 32'd4;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: fixed-latency in-order memory model, directed scenarios and a randomized run
// checked against an address-sequence reference (words are a pure function of their address).
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        imemReqValid;
    logic        imemReqReady = 1'b0;
    logic [31:0] imemAddr;
    logic        imemRspValid = 1'b0;
    logic [31:0] imemRspData = 32'h0;
    logic        instrValid;
    logic        instrReady = 1'b0;
    logic [31:0] instr;
    logic [31:0] instrPc;
    logic        redirectValid = 1'b0;
    logic [31:0] redirectPc = 32'h0;
    logic        fetchFault;

    int checks = 0;
    int failures = 0;
    int lat = 1;
    int cyc = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;
    req_t        mq[$];
    req_t        m_req;
    logic        m_acc;
    logic        m_done;
    logic [31:0] m_addr;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
        .clk(clk), .rstn(rstn),
        .imemReqValid(imemReqValid), .imemReqReady(imemReqReady), .imemAddr(imemAddr),
        .imemRspValid(imemRspValid), .imemRspData(imemRspData),
        .instrValid(instrValid), .instrReady(instrReady), .instr(instr), .instrPc(instrPc),
        .redirectValid(redirectValid), .redirectPc(redirectPc), .fetchFault(fetchFault)
    );

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h0100_0193) ^ 32'hA5A5_0F0F;
    endfunction

    // Memory: every accepted request answered exactly lat cycles later, in order.
    always @(posedge clk) begin
        m_acc  = rstn && imemReqValid && imemReqReady;
        m_done = imemRspValid;
        m_addr = imemAddr;
        #1;
        if (!rstn) begin
            mq.delete();
        end else begin
            if (m_done && mq.size() > 0) void'(mq.pop_front());
            if (m_acc) begin
                m_req.addr = m_addr;
                m_req.due  = cyc + lat;
                mq.push_back(m_req);
            end
        end
        cyc++;
        if (rstn && mq.size() > 0 && mq[0].due <= cyc) begin
            imemRspValid = 1'b1;
            imemRspData  = word_of(mq[0].addr);
        end else begin
            imemRspValid = 1'b0;
            imemRspData  = 32'h0;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset(input logic rq, input logic ir);
        rstn = 1'b0;
        redirectValid = 1'b0;
        redirectPc = 32'h0;
        imemReqReady = rq;
        instrReady = ir;
        repeat (2) @(posedge clk);
        #2;
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        imemReqReady = 1'b1;
        instrReady = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (imemReqValid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b exp=0", imemReqValid); end
        checks++; if (imemAddr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=00000000", imemAddr); end
        checks++; if (instrValid !== 1'b0) begin failures++; $display("FAIL reset_instr_valid got=%b exp=0", instrValid); end
        checks++; if (instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=00000000", instr); end
        checks++; if (instrPc !== 32'h0) begin failures++; $display("FAIL reset_instr_pc got=%h exp=00000000", instrPc); end
        checks++; if (fetchFault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b exp=0", fetchFault); end
        step();
        rstn = 1'b1;
        @(negedge clk);
        checks++; if (imemReqValid !== 1'b1) begin failures++; $display("FAIL first_req_valid got=%b exp=1", imemReqValid); end
        checks++; if (imemAddr !== 32'h0) begin failures++; $display("FAIL first_req_addr got=%h exp=00000000", imemAddr); end
        step();
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc = 32'h0;
        logic [31:0] exp_req = 32'h0;
        int pops = 0;
        int first_pop = -1;
        lat = 1;
        apply_reset(1'b1, 1'b1);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (imemReqValid && imemReqReady) begin
                checks++; if (imemAddr !== exp_req) begin failures++; $display("FAIL stream_req_addr got=%h exp=%h", imemAddr, exp_req); end
                exp_req += 32'd4;
            end
            if (instrValid && instrReady) begin
                if (first_pop < 0) first_pop = i;
                checks++; if (instrPc !== exp_pc) begin failures++; $display("FAIL stream_pc got=%h exp=%h", instrPc, exp_pc); end
                checks++; if (instr !== word_of(exp_pc)) begin failures++; $display("FAIL stream_instr got=%h exp=%h", instr, word_of(exp_pc)); end
                exp_pc += 32'd4;
                pops++;
            end
            step();
        end
        checks++; if (first_pop != 2) begin failures++; $display("FAIL stream_first_latency got=%0d exp=2", first_pop); end
        checks++; if (pops < 8) begin failures++; $display("FAIL stream_throughput got=%0d exp>=8", pops); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc = 32'h0;
        int accepts = 0;
        int pops = 0;
        lat = 1;
        apply_reset(1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (imemReqValid && imemReqReady) accepts++;
            step();
        end
        @(negedge clk);
        checks++; if (accepts != 2) begin failures++; $display("FAIL bp_accepts got=%0d exp=2", accepts); end
        checks++; if (instrValid !== 1'b1) begin failures++; $display("FAIL bp_instr_valid got=%b exp=1", instrValid); end
        checks++; if (imemReqValid !== 1'b0) begin failures++; $display("FAIL bp_req_valid got=%b exp=0", imemReqValid); end
        checks++; if (instrPc !== 32'h0) begin failures++; $display("FAIL bp_head_pc got=%h exp=00000000", instrPc); end
        step();
        instrReady = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (instrValid && instrReady) begin
                checks++; if (instrPc !== exp_pc) begin failures++; $display("FAIL bp_pc got=%h exp=%h", instrPc, exp_pc); end
                checks++; if (instr !== word_of(exp_pc)) begin failures++; $display("FAIL bp_instr got=%h exp=%h", instr, word_of(exp_pc)); end
                exp_pc += 32'd4;
                pops++;
            end
            step();
        end
        checks++; if (pops < 6) begin failures++; $display("FAIL bp_resume_pops got=%0d exp>=6", pops); end
    endtask

    task automatic test_redirect_inflight();
        logic [31:0] exp_pc = 32'h100;
        logic [31:0] exp_req = 32'h100;
        int accepts = 0;
        int pops = 0;
        lat = 3;
        apply_reset(1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (imemReqValid && imemReqReady) accepts++;
            step();
        end
        redirectValid = 1'b1;
        redirectPc = 32'h100;
        @(negedge clk);
        checks++; if (accepts != 2) begin failures++; $display("FAIL rdi_inflight got=%0d exp=2", accepts); end
        checks++; if (imemReqValid !== 1'b0) begin failures++; $display("FAIL rdi_req_in_redirect got=%b exp=0", imemReqValid); end
        step();
        redirectValid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (imemReqValid && imemReqReady) begin
                checks++; if (imemAddr !== exp_req) begin failures++; $display("FAIL rdi_req_addr got=%h exp=%h", imemAddr, exp_req); end
                exp_req += 32'd4;
            end
            if (instrValid && instrReady) begin
                checks++; if (instrPc !== exp_pc) begin failures++; $display("FAIL rdi_pc got=%h exp=%h", instrPc, exp_pc); end
                checks++; if (instr !== word_of(exp_pc)) begin failures++; $display("FAIL rdi_instr got=%h exp=%h", instr, word_of(exp_pc)); end
                exp_pc += 32'd4;
                pops++;
            end
            step();
        end
        checks++; if (pops < 2) begin failures++; $display("FAIL rdi_pops got=%0d exp>=2", pops); end
    endtask

    task automatic test_redirect_same_cycle();
        logic [31:0] exp_pc = 32'h40;
        int pops = 0;
        lat = 1;
        apply_reset(1'b1, 1'b1);
        step();
        step();
        redirectValid = 1'b1;
        redirectPc = 32'h40;
        @(negedge clk);
        checks++; if (imemRspValid !== 1'b1) begin failures++; $display("FAIL rsc_rsp_present got=%b exp=1", imemRspValid); end
        checks++; if (instrValid !== 1'b0) begin failures++; $display("FAIL rsc_valid_in_redirect got=%b exp=0", instrValid); end
        step();
        redirectValid = 1'b0;
        @(negedge clk);
        checks++; if (instrValid !== 1'b0) begin failures++; $display("FAIL rsc_fifo_empty got=%b exp=0", instrValid); end
        checks++; if (imemReqValid !== 1'b1) begin failures++; $display("FAIL rsc_req_valid got=%b exp=1", imemReqValid); end
        checks++; if (imemAddr !== 32'h40) begin failures++; $display("FAIL rsc_req_addr got=%h exp=00000040", imemAddr); end
        step();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (instrValid && instrReady) begin
                checks++; if (instrPc !== exp_pc) begin failures++; $display("FAIL rsc_pc got=%h exp=%h", instrPc, exp_pc); end
                exp_pc += 32'd4;
                pops++;
            end
            step();
        end
        checks++; if (pops < 3) begin failures++; $display("FAIL rsc_pops got=%0d exp>=3", pops); end
    endtask

    task automatic test_req_stall();
        int pops = 0;
        lat = 1;
        apply_reset(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (imemReqValid !== 1'b1) begin failures++; $display("FAIL stall_valid got=%b exp=1", imemReqValid); end
            checks++; if (imemAddr !== 32'h0) begin failures++; $display("FAIL stall_addr got=%h exp=00000000", imemAddr); end
            step();
        end
        imemReqReady = 1'b1;
        step();
        imemReqReady = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++; if (imemAddr !== 32'h4) begin failures++; $display("FAIL stall_next_addr got=%h exp=00000004", imemAddr); end
            if (instrValid && instrReady) begin
                checks++; if (instrPc !== 32'h0) begin failures++; $display("FAIL stall_pc got=%h exp=00000000", instrPc); end
                pops++;
            end
            step();
        end
        checks++; if (pops != 1) begin failures++; $display("FAIL stall_once got=%0d exp=1", pops); end
    endtask

    task automatic test_misaligned();
        logic [31:0] exp_pc;
        int pops = 0;
        lat = 1;
        apply_reset(1'b1, 1'b1);
        repeat (3) step();
        redirectValid = 1'b1;
        redirectPc = 32'h102;
        step();
        redirectValid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (fetchFault !== 1'b1) begin failures++; $display("FAIL mis_fault got=%b exp=1", fetchFault); end
            checks++; if (imemReqValid !== 1'b0) begin failures++; $display("FAIL mis_req_held got=%b exp=0", imemReqValid); end
            step();
        end
        redirectValid = 1'b1;
        redirectPc = 32'h200;
        step();
        redirectValid = 1'b0;
        exp_pc = 32'h200;
`else
        exp_pc = 32'h100;
`endif
        @(negedge clk);
        checks++; if (fetchFault !== 1'b0) begin failures++; $display("FAIL mis_fault_clear got=%b exp=0", fetchFault); end
        checks++; if (imemReqValid !== 1'b1) begin failures++; $display("FAIL mis_resume_valid got=%b exp=1", imemReqValid); end
        checks++; if (imemAddr !== exp_pc) begin failures++; $display("FAIL mis_resume_addr got=%h exp=%h", imemAddr, exp_pc); end
        step();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (instrValid && instrReady) begin
                checks++; if (instrPc !== exp_pc) begin failures++; $display("FAIL mis_pc got=%h exp=%h", instrPc, exp_pc); end
                exp_pc += 32'd4;
                pops++;
            end
            step();
        end
        checks++; if (pops < 2) begin failures++; $display("FAIL mis_pops got=%0d exp>=2", pops); end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] exp_req;
        logic [31:0] stall_addr;
        logic        stall_prev;
        int pops = 0;
        for (int blk = 0; blk < 3; blk++) begin
            lat = blk + 1;
            apply_reset(1'b1, 1'b1);
            exp_pc = 32'h0;
            exp_req = 32'h0;
            stall_prev = 1'b0;
            stall_addr = 32'h0;
            for (int i = 0; i < 300; i++) begin
                imemReqReady = ($urandom % 4) != 0;
                instrReady = ($urandom % 3) != 0;
                redirectValid = ($urandom % 16) == 0;
                redirectPc = 32'($urandom_range(0, 255)) << 2;
                @(negedge clk);
                if (stall_prev && !redirectValid) begin
                    checks++; if (imemReqValid !== 1'b1 || imemAddr !== stall_addr) begin failures++; $display("FAIL rnd_stall_hold got=%b/%h exp=1/%h", imemReqValid, imemAddr, stall_addr); end
                end
                if (redirectValid) begin
                    checks++; if (imemReqValid !== 1'b0 || instrValid !== 1'b0) begin failures++; $display("FAIL rnd_redirect_quiet got=%b/%b exp=0/0", imemReqValid, instrValid); end
                    exp_pc = redirectPc;
                    exp_req = redirectPc;
                end else begin
                    if (imemReqValid && imemReqReady) begin
                        checks++; if (imemAddr !== exp_req) begin failures++; $display("FAIL rnd_req_addr got=%h exp=%h", imemAddr, exp_req); end
                        exp_req += 32'd4;
                    end
                    if (instrValid && instrReady) begin
                        checks++; if (instrPc !== exp_pc || instr !== word_of(exp_pc)) begin failures++; $display("FAIL rnd_instr got=%h@%h exp=%h@%h", instr, instrPc, word_of(exp_pc), exp_pc); end
                        exp_pc += 32'd4;
                        pops++;
                    end
                end
                stall_prev = imemReqValid && !imemReqReady;
                stall_addr = imemAddr;
                step();
            end
        end
        redirectValid = 1'b0;
        checks++; if (pops < 100) begin failures++; $display("FAIL rnd_progress got=%0d exp>=100", pops); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_same_cycle();
        test_req_stall();
        test_misaligned();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the core. Holds the program counter, issues word requests to instruction memory over a valid/ready channel, buffers in-order responses in a small FIFO and presents instruction/PC pairs to decode, where the immediate extender and control decoder consume the instruction word. Branch/jump targets from execute arrive as redirects; the fetch stage flushes its buffer and discards stale in-flight responses.

## Interface
- RESET_PC, 32'h00000000, first fetch address after reset
- BUF_DEPTH, 2, instruction buffer entries and maximum in-flight requests plus buffered words (power of two, ≥2)

- clk  in  1  clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- imemReqValid  out  1  fetch request valid
- imemReqReady  in  1  memory accepts request
- imemAddr  out  32  word address of request (bits [1:0] always 00)
- imemRspValid  in  1  response valid, in request order, never back-pressured
- imemRspData  in  32  instruction word
- instrValid  out  1  instruction available to decode
- instrReady  in  1  decode accepts instruction
- instr  out  32  instruction word
- instrPc  out  32  address of instr
- redirectValid  in  1  control-flow redirect from execute
- redirectPc  in  32  redirect target
- fetchFault  out  1  misaligned redirect flag (see Configuration)

## Operation
- State: reqPc (next request address), rspPc (address of next expected kept response), outstanding (in-flight requests, 0..BUF_DEPTH), dropCnt (in-flight responses to discard), FIFO of {instr, pc} with count.
- Request: imemReqValid = !redirectValid && !fault && (outstanding + count) < BUF_DEPTH; imemAddr = reqPc. On accept: reqPc += 4 (wraps mod 2^32), outstanding++.
- Response: outstanding--. If dropCnt != 0: discard, dropCnt--. Else push {imemRspData, rspPc}, rspPc += 4. Push never overflows by the credit rule.
- Output: instrValid = count != 0 && !redirectValid; instr/instrPc = FIFO head. Pop on instrValid && instrReady.
- Redirect (highest priority): FIFO flushed, reqPc <= redirectPc, rspPc <= redirectPc, dropCnt <= outstanding − imemRspValid (all remaining in-flight responses become stale; a response arriving in the redirect cycle is discarded). No request is issued and no pop occurs in the redirect cycle.
- Simultaneous accept and response in one cycle: outstanding unchanged.
- Redirect while dropCnt != 0: new dropCnt replaces old per the rule above (covers all in-flight).

## Timing
- Reset values: reqPc = rspPc = RESET_PC, outstanding = dropCnt = count = 0, FIFO contents 0; imemReqValid 0 while rstn low, imemAddr RESET_PC, instrValid 0, instr 0, instrPc 0, fetchFault 0.
- First request offered in the first cycle after rstn deasserts.
- Response at cycle N → instrValid at cycle N+1 (registered FIFO write); minimum fetch-to-decode latency = memory latency + 1.
- Redirect in cycle R → imemReqValid with imemAddr = redirectPc in cycle R+1 (if credit available).
- imemAddr changes only on request accept or redirect; imemReqValid may drop only on redirect or fault.
- Reset mid-operation: all state cleared immediately; pending memory responses after reset are the memory's responsibility to squash.

## Configuration
- FETCH_ALIGN_CHECK_EN defined: redirect with redirectPc[1:0] != 00 sets fetchFault (sticky) and holds imemReqValid low; FIFO flushed and stale responses dropped as normal. Cleared by a redirect with aligned target or by reset.
- Not defined: redirectPc[1:0] forced to 00; fetchFault tied 0.

## Test plan
- Reset release, RESET_PC=0, 1-cycle memory, instrReady=1 → requests at 0,4,8,…; instr/instrPc pairs emitted in order, one per cycle steady state.
- instrReady=0 with BUF_DEPTH=2 → exactly 2 words buffered, imemReqValid low; releasing instrReady resumes at next address with no loss or duplication.
- Two requests in flight (3-cycle latency), redirect to 32'h00000100 → both stale responses discarded, next instrPc = 32'h00000100.
- Redirect in same cycle as response and pending pop → response discarded, no pop, FIFO empty next cycle.
- imemReqReady held low 5 cycles → imemAddr stable at same value throughout, accepted once.
- FETCH_ALIGN_CHECK_EN: redirect to 32'h00000102 → fetchFault=1, no requests; redirect to 32'h00000200 → fetchFault=0, fetch resumes at 32'h00000200.
